// File: rtl/zx_spi_pkg.sv
// Shared definitions for the SPI2 control link into the ZX expander shadow
// registers: target address codes, frame lengths, FSM encoding and the bit
// layout of the config shadow.
package zx_spi_pkg;

  // SPI_A target codes
  localparam logic [1:0] SPI_ADR_CONFIG = 2'b00;
  localparam logic [1:0] SPI_ADR_MOUSE  = 2'b01;
  localparam logic [1:0] SPI_ADR_KMPST  = 2'b10;
  localparam logic [1:0] SPI_ADR_KBD    = 2'b11;

  // Exact frame lengths in bits
  localparam logic [5:0] LEN_CFG   = 6'd8;
  localparam logic [5:0] LEN_MOUSE = 6'd24;
  localparam logic [5:0] LEN_KMP   = 6'd8;
  localparam logic [5:0] LEN_KBD   = 6'd40;

  // Config shadow bit positions
  localparam int CFG_MOUSE     = 0;
  localparam int CFG_KBD       = 1;
  localparam int CFG_KMPSTN    = 2;
  localparam int CFG_FDD_SWAP  = 3;
  localparam int CFG_128K_LOCK = 4;
  localparam int CFG_PSG_A15   = 5;
  localparam int CFG_OUT_1     = 6;
  localparam int CFG_WAIT      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ABORT = 2'd3
  } spi_state_e;

  function automatic logic [5:0] frame_len(input logic [1:0] adr);
    case (adr)
      SPI_ADR_CONFIG: frame_len = LEN_CFG;
      SPI_ADR_MOUSE:  frame_len = LEN_MOUSE;
      SPI_ADR_KMPST:  frame_len = LEN_KMP;
      default:        frame_len = LEN_KBD;
    endcase
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchroniser chain for W asynchronous bits with optional rise/fall
// detection on the synchronised value.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   d_i   [W]       : asynchronous input
//   q_o   [W]       : synchronised value (last chain stage)
//   rise_o/fall_o   : one-cycle edge strobes (tied 0 when EDGE == 0)
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter int   W       = 1,
  parameter bit   EDGE    = 1'b1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [STAGES-1:0][W-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) chain_q <= {(STAGES*W){RST_VAL}};
    else       chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] prev_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= {W{RST_VAL}};
        else       prev_q <= q_o;
      end
      assign rise_o = q_o & ~prev_q;
      assign fall_o = ~q_o & prev_q;
    end else begin : g_no_edge
      assign rise_o = '0;
      assign fall_o = '0;
    end
  endgenerate

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI2 frame sequencer: synchronises the SPI link, shifts one frame per
// NSS-low window, checks its exact length and commits it atomically to the
// addressed shadow register once the Z80 is not mid-read.
// Ports:
//   CLK14M, RST                 : clock, synchronous active-high reset
//   SPI_SCK/NSS/MOSI, SPI_A[2]  : asynchronous SPI link + target select
//   BUS_BUSY                    : Z80 read of a shadow-backed port in flight
//   CFG_Q/MOUSE_Q/KMP_Q/KBD_Q   : shadow registers
//   UPD[4]                      : one-hot commit strobe
//   FRAME_ERR, ERR_CNT          : reject pulse and its saturating count
module spi_frame_ctrl
  import zx_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095,
  parameter int ERR_W       = 8
) (
  input  logic             CLK14M,
  input  logic             RST,
  input  logic             SPI_SCK,
  input  logic             SPI_NSS,
  input  logic             SPI_MOSI,
  input  logic [1:0]       SPI_A,
  input  logic             BUS_BUSY,
  output logic [7:0]       CFG_Q,
  output logic [23:0]      MOUSE_Q,
  output logic [7:0]       KMP_Q,
  output logic [39:0]      KBD_Q,
  output logic [3:0]       UPD,
  output logic             FRAME_ERR,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  // ---------------- input synchronisers ----------------
  logic       sck_s, sck_rise, sck_fall_unused;
  logic       nss_s, nss_rise, nss_fall;
  logic       mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic [1:0] a_s, a_rise_unused, a_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .W(1), .EDGE(1'b1)) u_sync_sck (
    .clk_i(CLK14M), .rst_i(RST), .d_i(SPI_SCK),
    .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall_unused)
  );

  // Resets low so a frame already in progress at reset release is never
  // seen as a falling edge.
  spi_in_sync #(.STAGES(SYNC_STAGES), .W(1), .EDGE(1'b1)) u_sync_nss (
    .clk_i(CLK14M), .rst_i(RST), .d_i(SPI_NSS),
    .q_o(nss_s), .rise_o(nss_rise), .fall_o(nss_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .W(1), .EDGE(1'b0)) u_sync_mosi (
    .clk_i(CLK14M), .rst_i(RST), .d_i(SPI_MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .W(2), .EDGE(1'b0)) u_sync_a (
    .clk_i(CLK14M), .rst_i(RST), .d_i(SPI_A),
    .q_o(a_s), .rise_o(a_rise_unused), .fall_o(a_fall_unused)
  );

  // ---------------- state ----------------
  spi_state_e       state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [39:0]      shift_q, shift_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             drop_q, drop_d;   // a frame started while in HOLD
  logic [7:0]       cfg_q, cfg_d;
  logic [23:0]      mouse_q, mouse_d;
  logic [7:0]       kmp_q, kmp_d;
  logic [39:0]      kbd_q, kbd_d;
  logic [3:0]       upd_q, upd_d;
  logic             ferr_q, ferr_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             bit_in;
  logic [5:0]       cnt_inc;

  // Keyboard frames are sent active-low on the wire.
  assign bit_in  = (addr_q == SPI_ADR_KBD) ? ~mosi_s : mosi_s;
  assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    drop_d  = drop_q;
    cfg_d   = cfg_q;
    mouse_d = mouse_q;
    kmp_d   = kmp_q;
    kbd_d   = kbd_q;
    upd_d   = '0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (nss_fall) begin
          addr_d  = a_s;
          shift_d = '0;
          cnt_d   = '0;
          to_d    = '0;
          drop_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (sck_rise) begin
          shift_d = {shift_q[38:0], bit_in};
          cnt_d   = cnt_inc;
          to_d    = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
        // Length check uses cnt_d so a final SCK coincident with NSS rise
        // is counted.
        if (nss_rise) begin
          if (cnt_d == frame_len(addr_q)) begin
            state_d = ST_HOLD;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!sck_rise && to_q == TO_W'(TIMEOUT - 1)) begin
          ferr_d  = 1'b1;
          state_d = ST_ABORT;
        end
      end

      ST_HOLD: begin
        if (nss_fall) begin
          ferr_d = 1'b1;
          drop_d = 1'b1;
        end
        if (!BUS_BUSY) begin
          case (addr_q)
            SPI_ADR_CONFIG: cfg_d   = shift_q[7:0];
            SPI_ADR_MOUSE:  mouse_d = shift_q[23:0];
            SPI_ADR_KMPST:  kmp_d   = shift_q[7:0];
            default:        kbd_d   = shift_q;
          endcase
          upd_d[addr_q] = 1'b1;
          state_d = (drop_q || nss_fall) ? ST_ABORT : ST_IDLE;
        end
      end

      ST_ABORT: begin
        if (nss_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (ferr_d && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK14M) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      drop_q    <= 1'b0;
      cfg_q     <= '0;
      mouse_q   <= '0;
      kmp_q     <= '0;
      kbd_q     <= '0;
      upd_q     <= '0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      drop_q    <= drop_d;
      cfg_q     <= cfg_d;
      mouse_q   <= mouse_d;
      kmp_q     <= kmp_d;
      kbd_q     <= kbd_d;
      upd_q     <= upd_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign CFG_Q     = cfg_q;
  assign MOUSE_Q   = mouse_q;
  assign KMP_Q     = kmp_q;
  assign KBD_Q     = kbd_q;
  assign UPD       = upd_q;
  assign FRAME_ERR = ferr_q;
  assign ERR_CNT   = err_cnt_q;

endmodule
